rtc_cmd_bridge: RTL and testbench
=================================

Name: rtc_cmd_bridge

Overview:
Command-issue stage that sits directly upstream of the real-time-clock peripheral. It buffers 24-bit commands from the CPU/bus side in a small FIFO and replays them one at a time as single-cycle start pulses on the peripheral's command port. For response-bearing commands (GET) it captures the peripheral's 24-bit reply, or generates a timeout reply, and returns it over a valid/ready response channel.

Parameters:
DEPTH, 4, command FIFO depth; power of two, minimum 2.
TIMEOUT, 16, cycles to wait for per_rdy after the issue cycle before declaring a timeout; range 1..255.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  upstream command valid.
cmd_ready  out  1  FIFO can accept; equals !full.
cmd_data  in  24  command: [23:16] opcode, [15:0] operand.
per_start  out  1  one-cycle command strobe to the peripheral.
per_in  out  24  command presented to the peripheral; valid while per_start=1, else 0.
per_rdy  in  1  peripheral reply valid; may be combinational in the same cycle as per_start.
per_out  in  24  peripheral reply data.
rsp_valid  out  1  response available.
rsp_ready  in  1  downstream accepts the response.
rsp_data  out  24  response: {opcode, 16-bit data}.
rsp_timeout  out  1  qualifies rsp_data; 1 means the reply timed out.
busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset: FIFO emptied (count=0, pointers=0), FSM to IDLE, timer=0. All outputs 0 except cmd_ready=1. rst mid-transaction aborts that transaction: no per_start and no response is produced for the aborted command.
- FIFO: push when cmd_valid && cmd_ready. Pop only in IDLE when non-empty. Push and pop in the same cycle leaves count unchanged. When full, cmd_ready=0; there is no same-cycle bypass. Pointers wrap modulo DEPTH.
- Opcodes (shared constants): RUN=1, STOP=2, SET=3, GET=4, ON=5, OFF=6. Only GET expects a reply. All other opcode values, including undefined ones, are forwarded unmodified as fire-and-forget.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into cur_cmd and go to ISSUE.
  - ISSUE: per_start=1 and per_in=cur_cmd for exactly one cycle.
    - Non-GET: go to IDLE.
    - GET with per_rdy=1 this cycle: capture per_out into rsp_data, set rsp_timeout=0, go to RESP.
    - GET with per_rdy=0: clear the timer and go to WAIT.
  - WAIT: per_start=0; timer increments each cycle.
    - per_rdy=1: capture per_out, set rsp_timeout=0, go to RESP.
    - Otherwise, when timer reaches TIMEOUT-1: rsp_data={cur_cmd[23:16],16'hFFFF}, set rsp_timeout=1, go to RESP.
    - per_rdy takes priority over timeout in the same cycle.
  - RESP: rsp_valid=1 with rsp_data and rsp_timeout held stable. When rsp_ready=1, go to IDLE. The FIFO keeps accepting commands during RESP, but nothing is issued.
- Latency: command accepted at edge k on an empty FIFO in IDLE → per_start high in cycle k+2 (IDLE pop in cycle k+1, ISSUE in cycle k+2). A GET with same-cycle per_rdy → rsp_valid in cycle k+3. Back-to-back non-GET commands issue every 2 cycles.
- per_rdy is ignored in IDLE and RESP. A late reply arriving after a timeout is discarded.
- Registered outputs: rsp_valid, rsp_data, rsp_timeout. per_start and per_in are decoded from the FSM state and cur_cmd, with no input-to-output combinational path.

Decomposition:
- Shared package/header rtc_cmd_pkg: opcode constants RUN..OFF, opcode field slice bounds [23:16], data field width 16, and TIMEOUT_DATA=16'hFFFF.
- One sub-module, cmd_fifo: synchronous FIFO with DEPTH and WIDTH=24 parameters, push/pop, full/empty/count outputs.
- The FSM and timer live in rtc_cmd_bridge.

Test Plan:
- Reset, then push {8'd1,16'h0000} (RUN) → per_start=1 with per_in=24'h010000 exactly 2 cycles after acceptance; rsp_valid stays 0; busy returns to 0.
- Push GET 24'h040000 with a peripheral model returning per_rdy same-cycle and per_out=24'h041234 → rsp_valid in cycle k+3, rsp_data=24'h041234, rsp_timeout=0. With rsp_ready held 0 for 5 cycles, rsp_valid and rsp_data stay stable.
- GET with per_rdy tied 0, TIMEOUT=16 → rsp_data=24'h04FFFF and rsp_timeout=1 after 16 WAIT cycles. A per_rdy pulse arriving afterwards is ignored.
- Push 5 commands back-to-back while per_start is stalled in RESP (DEPTH=4) → cmd_ready=0 after 4 entries. After rsp_ready, commands issue in push order: SET 24'h03ABCD, ON 24'h050002, OFF 24'h060002, STOP 24'h020000.
- Simultaneous push and pop with 2 entries queued → count stays at 2. Pointer wrap after 9 pushes/pops preserves command order.
- Assert rst in the WAIT state of a GET → next cycle: rsp_valid=0, cmd_ready=1, busy=0, FIFO empty, no response emitted.

Source files
------------

// File: rtl/rtc_cmd_pkg.sv
// -----------------------------------------------------------------------------
// rtc_cmd_pkg
// Shared definitions for the RTC command bridge: opcode constants, command
// field layout, timeout reply payload and the bridge FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package rtc_cmd_pkg;

    localparam int CMD_W  = 24;
    localparam int OP_HI  = 23;
    localparam int OP_LO  = 16;
    localparam int DATA_W = 16;

    localparam logic [7:0] OP_RUN  = 8'd1;
    localparam logic [7:0] OP_STOP = 8'd2;
    localparam logic [7:0] OP_SET  = 8'd3;
    localparam logic [7:0] OP_GET  = 8'd4;
    localparam logic [7:0] OP_ON   = 8'd5;
    localparam logic [7:0] OP_OFF  = 8'd6;

    // Payload returned in place of peripheral data when a GET times out.
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Only GET waits for a peripheral reply; every other opcode, including
    // undefined ones, is fire-and-forget.
    function automatic logic expects_reply(input logic [CMD_W-1:0] cmd);
        return (cmd[OP_HI:OP_LO] == OP_GET);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding pending commands. Head entry is presented
// combinationally on pop_data; push is ignored when full, pop when empty.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write request and data
//   pop                 remove head entry
//   pop_data            current head entry
//   full, empty, count  occupancy status
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == CW'(0));
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];
    assign push_s   = push && !full;
    assign pop_s    = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while the entry is unoccupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/rtc_cmd_bridge.sv
// -----------------------------------------------------------------------------
// rtc_cmd_bridge
// Buffers CPU commands and replays them one at a time to the RTC peripheral as
// single-cycle start strobes. GET commands wait for the peripheral reply (or a
// timeout) and return it on a valid/ready response channel.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid, cmd_ready, cmd_data   command input (ready = FIFO not full)
//   per_start, per_in                command strobe/data to peripheral
//   per_rdy, per_out                 peripheral reply
//   rsp_valid, rsp_ready, rsp_data,
//   rsp_timeout                      registered response channel
//   busy                             FSM active or commands pending
// -----------------------------------------------------------------------------
module rtc_cmd_bridge
    import rtc_cmd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_data,
    output logic        per_start,
    output logic [23:0] per_in,
    input  logic        per_rdy,
    input  logic [23:0] per_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [23:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t              state_r;
    state_t              state_nx_s;
    logic [CMD_W-1:0]    cur_cmd_r;
    logic [7:0]          timer_r;
    logic                rsp_valid_r;
    logic [CMD_W-1:0]    rsp_data_r;
    logic                rsp_timeout_r;

    logic                fifo_pop_s;
    logic [CMD_W-1:0]    fifo_head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;

    logic                cap_s;
    logic [CMD_W-1:0]    cap_data_s;
    logic                cap_to_s;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_data),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign cmd_ready   = !fifo_full_s;
    assign per_start   = (state_r == ST_ISSUE);
    assign per_in      = (state_r == ST_ISSUE) ? cur_cmd_r : 24'h000000;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_timeout = rsp_timeout_r;
    assign busy        = (state_r != ST_IDLE) || (fifo_count_s != '0);

    // Next-state decode plus response capture selection.
    always_comb begin
        state_nx_s = state_r;
        fifo_pop_s = 1'b0;
        cap_s      = 1'b0;
        cap_data_s = 24'h000000;
        cap_to_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (expects_reply(cur_cmd_r)) begin
                    if (per_rdy) begin
                        cap_s      = 1'b1;
                        cap_data_s = per_out;
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A reply in the final wait cycle still wins over the timeout.
                if (per_rdy) begin
                    cap_s      = 1'b1;
                    cap_data_s = per_out;
                    state_nx_s = ST_RESP;
                end else if (timer_r == TIMER_LAST) begin
                    cap_s      = 1'b1;
                    cap_data_s = {cur_cmd_r[OP_HI:OP_LO], TIMEOUT_DATA};
                    cap_to_s   = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, current command, wait timer and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cur_cmd_r     <= 24'h000000;
            timer_r       <= 8'd0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 24'h000000;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            rsp_valid_r <= (state_nx_s == ST_RESP);
            if (fifo_pop_s) begin
                cur_cmd_r <= fifo_head_s;
            end
            if (state_r == ST_ISSUE) begin
                timer_r <= 8'd0;
            end else if (state_r == ST_WAIT) begin
                timer_r <= timer_r + 8'd1;
            end
            if (cap_s) begin
                rsp_data_r    <= cap_data_s;
                rsp_timeout_r <= cap_to_s;
            end
        end
    end

endmodule

// File: tb/tb_rtc_cmd_bridge.sv
// -----------------------------------------------------------------------------
// tb_rtc_cmd_bridge
// Scoreboard bench for rtc_cmd_bridge: expected issues and responses are
// queued as commands are pushed and compared when the DUT emits them.
// Cycle numbering: a command accepted at edge K is followed by "cycle k+1";
// the negedge of cycle k+n observes cyc == K+n-1.
// -----------------------------------------------------------------------------
module tb_rtc_cmd_bridge;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_data;
    logic        per_start;
    logic [23:0] per_in;
    logic        per_rdy;
    logic [23:0] per_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    logic        auto_rdy;
    logic [23:0] auto_out;
    logic        man_rdy;
    logic [23:0] man_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [23:0] exp_issue[$];
    logic [24:0] exp_rsp[$];
    logic [23:0] obs_data[$];
    int          obs_cyc[$];

    rtc_cmd_bridge #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .per_start   (per_start),
        .per_in      (per_in),
        .per_rdy     (per_rdy),
        .per_out     (per_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    // Peripheral model: either answers in the issue cycle or is driven by hand.
    assign per_rdy = auto_rdy ? per_start : man_rdy;
    assign per_out = auto_rdy ? auto_out : man_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every issue strobe with the cycle it appeared in.
    always @(negedge clk) begin
        if (per_start === 1'b1) begin
            obs_data.push_back(per_in);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before 300000ns");
        $fatal(1);
    end

    // Drive one command for one cycle; called at posedge+1, returns at posedge+1.
    task automatic push_one(input logic [23:0] d, output bit acc);
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(negedge clk);
        acc = (cmd_ready === 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 24'h000000;
        if (acc) exp_issue.push_back(d);
    endtask

    // Wait (bounded) until at least n issues have been observed.
    task automatic wait_obs(input int n, output bit ok);
        int t;
        t = 0;
        while (t < 300 && obs_data.size() < n) begin
            @(negedge clk);
            t++;
        end
        ok = (obs_data.size() >= n);
    endtask

    // Wait (bounded) for rsp_valid; returns the cycle it was seen.
    task automatic wait_rsp(output bit ok, output int when);
        int t;
        t = 0;
        @(negedge clk);
        while (t < 60 && rsp_valid !== 1'b1) begin
            @(negedge clk);
            t++;
        end
        ok   = (rsp_valid === 1'b1);
        when = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        n_cmp++; if (per_start !== 1'b0 || per_in !== 24'h0) begin n_fail++; $display("FAIL reset_per: got %b/%h required 0/000000", per_start, per_in); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got %b/%b required 0/0", rsp_valid, rsp_timeout); end
        n_cmp++; if (rsp_data !== 24'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h required 000000", rsp_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_run();
        bit acc, ok;
        int k;
        logic [23:0] e;
        push_one(24'h010000, acc);
        k = cyc;
        n_cmp++; if (!acc) begin n_fail++; $display("FAIL run_accept: got 0 required 1"); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy_pending: got %b required 1", busy); end
        wait_obs(1, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL run_issue: got no per_start required one");
        end else begin
            e = exp_issue.pop_front();
            n_cmp++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL run_per_in: got %h required %h", obs_data[0], e); end
            n_cmp++; if (obs_cyc[0] !== k + 1) begin n_fail++; $display("FAIL run_latency: got cyc %0d required %0d", obs_cyc[0], k + 1); end
            void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL run_no_rsp: got %b required 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_busy_idle: got %b required 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_get_same();
        bit acc, ok;
        int k, when;
        logic [24:0] er;
        logic [23:0] e;
        auto_rdy = 1'b1;
        auto_out = 24'h041234;
        rsp_ready = 1'b0;
        exp_rsp.push_back({1'b0, 24'h041234});
        push_one(24'h040000, acc);
        k = cyc;
        wait_rsp(ok, when);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL get_rsp: got no rsp_valid required one");
        end else begin
            er = exp_rsp.pop_front();
            n_cmp++; if (when !== k + 2) begin n_fail++; $display("FAIL get_rsp_latency: got cyc %0d required %0d", when, k + 2); end
            n_cmp++; if (rsp_data !== er[23:0]) begin n_fail++; $display("FAIL get_rsp_data: got %h required %h", rsp_data, er[23:0]); end
            n_cmp++; if (rsp_timeout !== er[24]) begin n_fail++; $display("FAIL get_rsp_timeout: got %b required %b", rsp_timeout, er[24]); end
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_data !== er[23:0] || rsp_timeout !== er[24]) begin
                    n_fail++; $display("FAIL get_hold: got %b/%h/%b required 1/%h/%b", rsp_valid, rsp_data, rsp_timeout, er[23:0], er[24]);
                end
            end
        end
        wait_obs(1, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL get_issue: got no per_start required one");
        end else begin
            e = exp_issue.pop_front();
            n_cmp++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL get_per_in: got %h required %h", obs_data[0], e); end
            n_cmp++; if (obs_cyc[0] !== k + 1) begin n_fail++; $display("FAIL get_issue_latency: got cyc %0d required %0d", obs_cyc[0], k + 1); end
            void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL get_release: got valid %b busy %b required 0/0", rsp_valid, busy); end
        auto_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        bit acc, ok, extra;
        int k, when;
        logic [24:0] er;
        logic [23:0] e;
        man_rdy = 1'b0;
        exp_rsp.push_back({1'b1, 24'h04FFFF});
        push_one(24'h040000, acc);
        k = cyc;
        wait_rsp(ok, when);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL to_rsp: got no rsp_valid required one");
        end else begin
            er = exp_rsp.pop_front();
            n_cmp++; if (when !== k + 18) begin n_fail++; $display("FAIL to_latency: got cyc %0d required %0d", when, k + 18); end
            n_cmp++; if (rsp_data !== er[23:0] || rsp_timeout !== er[24]) begin n_fail++; $display("FAIL to_rsp_data: got %h/%b required %h/%b", rsp_data, rsp_timeout, er[23:0], er[24]); end
            @(posedge clk); #1; man_rdy = 1'b1; man_out = 24'h04AAAA;
            @(posedge clk); #1; man_rdy = 1'b0;
            @(negedge clk);
            n_cmp++; if (rsp_data !== er[23:0] || rsp_timeout !== 1'b1) begin n_fail++; $display("FAIL to_late_reply: got %h/%b required %h/1", rsp_data, rsp_timeout, er[23:0]); end
        end
        wait_obs(1, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL to_issue: got no per_start required one");
        end else begin
            e = exp_issue.pop_front();
            n_cmp++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL to_per_in: got %h required %h", obs_data[0], e); end
            void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0; man_rdy = 1'b1;
        @(posedge clk); #1; man_rdy = 1'b0;
        extra = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) extra = 1'b1;
        end
        n_cmp++; if (extra !== 1'b0 || obs_data.size() != 0) begin n_fail++; $display("FAIL to_idle_rdy_ignored: got rsp %b issues %0d required 0/0", extra, obs_data.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_late_rdy();
        bit acc, ok;
        int k, t;
        logic [23:0] e;
        man_rdy = 1'b0;
        push_one(24'h040000, acc);
        k = cyc;
        t = 0;
        while (cyc != k + 16 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1; man_rdy = 1'b1; man_out = 24'h04CCCC;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL late_early_rsp: got %b required 0", rsp_valid); end
        @(posedge clk); #1; man_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL late_rsp_valid: got %b required 1", rsp_valid); end
        n_cmp++; if (rsp_data !== 24'h04CCCC || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL late_rsp_data: got %h/%b required 04cccc/0", rsp_data, rsp_timeout); end
        wait_obs(1, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL late_issue: got no per_start required one");
        end else begin
            e = exp_issue.pop_front();
            n_cmp++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL late_per_in: got %h required %h", obs_data[0], e); end
            void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit acc, ok;
        int when, prev;
        logic [24:0] er;
        logic [23:0] e;
        logic [23:0] cmds [5];
        bit acc_exp [5];
        cmds = '{24'h03ABCD, 24'h050002, 24'h060002, 24'h020000, 24'h01FFFF};
        acc_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        auto_rdy = 1'b1;
        auto_out = 24'h04BEEF;
        rsp_ready = 1'b0;
        exp_rsp.push_back({1'b0, 24'h04BEEF});
        push_one(24'h040000, acc);
        wait_rsp(ok, when);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            push_one(cmds[i], acc);
            n_cmp++; if (acc !== acc_exp[i]) begin n_fail++; $display("FAIL fill_accept%0d: got %b required %b", i, acc, acc_exp[i]); end
        end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_cmd_ready: got %b required 0", cmd_ready); end
        n_cmp++; if (obs_data.size() != 1) begin n_fail++; $display("FAIL fill_stalled: got %0d issues required 1", obs_data.size()); end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL fill_rsp: got %b required 1", rsp_valid);
        end else begin
            er = exp_rsp.pop_front();
            n_cmp++; if (rsp_data !== er[23:0]) begin n_fail++; $display("FAIL fill_rsp_data: got %h required %h", rsp_data, er[23:0]); end
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        wait_obs(5, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL fill_issue: got %0d issues required 5", obs_data.size());
        end else begin
            prev = 0;
            for (int i = 0; i < 5; i++) begin
                e = exp_issue.pop_front();
                n_cmp++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL fill_order%0d: got %h required %h", i, obs_data[0], e); end
                if (i >= 2) begin
                    n_cmp++; if (obs_cyc[0] - prev !== 2) begin n_fail++; $display("FAIL fill_rate%0d: got gap %0d required 2", i, obs_cyc[0] - prev); end
                end
                prev = obs_cyc[0];
                void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
            end
        end
        repeat (6) @(negedge clk);
        n_cmp++; if (obs_data.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL fill_drained: got issues %0d busy %b required 0/0", obs_data.size(), busy); end
        auto_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_push_pop();
        bit acc, ok;
        int when;
        logic [24:0] er;
        logic [23:0] e;
        auto_rdy = 1'b1;
        auto_out = 24'h040777;
        rsp_ready = 1'b0;
        exp_rsp.push_back({1'b0, 24'h040777});
        push_one(24'h040000, acc);
        wait_rsp(ok, when);
        @(posedge clk); #1;
        push_one(24'h03000A, acc);
        push_one(24'h03000B, acc);
        n_cmp++; if (dut.u_fifo.count !== 3'd2) begin n_fail++; $display("FAIL pp_count_before: got %0d required 2", dut.u_fifo.count); end
        er = exp_rsp.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== er[23:0]) begin n_fail++; $display("FAIL pp_rsp: got %b/%h required 1/%h", rsp_valid, rsp_data, er[23:0]); end
        rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        push_one(24'h03000C, acc);
        @(negedge clk);
        n_cmp++; if (dut.u_fifo.count !== 3'd2) begin n_fail++; $display("FAIL pp_count_same: got %0d required 2", dut.u_fifo.count); end
        wait_obs(4, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL pp_issue: got %0d issues required 4", obs_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = exp_issue.pop_front();
                n_cmp++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL pp_order%0d: got %h required %h", i, obs_data[0], e); end
                void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
            end
        end
        auto_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        bit acc, ok;
        logic [23:0] e;
        for (int i = 0; i < 9; i++) begin
            push_one({8'h80 + 8'(i), 16'h1000 + 16'(i)}, acc);
            n_cmp++; if (!acc) begin n_fail++; $display("FAIL wrap_accept%0d: got 0 required 1", i); end
            @(posedge clk); #1;
        end
        wait_obs(9, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL wrap_issue: got %0d issues required 9", obs_data.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                e = exp_issue.pop_front();
                n_cmp++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL wrap_order%0d: got %h required %h", i, obs_data[0], e); end
                void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_abort();
        bit acc, ok, extra;
        logic [23:0] e;
        man_rdy = 1'b0;
        push_one(24'h040000, acc);
        wait_obs(1, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL abort_issue: got no per_start required one");
        end else begin
            e = exp_issue.pop_front();
            n_cmp++; if (obs_data[0] !== e) begin n_fail++; $display("FAIL abort_per_in: got %h required %h", obs_data[0], e); end
            void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        push_one(24'h010000, acc);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        // The queued RUN is flushed by the reset and must never issue.
        exp_issue.delete();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_state: got valid %b ready %b busy %b required 0/1/0", rsp_valid, cmd_ready, busy); end
        n_cmp++; if (dut.u_fifo.count !== 3'd0) begin n_fail++; $display("FAIL abort_fifo: got %0d required 0", dut.u_fifo.count); end
        extra = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) extra = 1'b1;
        end
        n_cmp++; if (extra !== 1'b0 || obs_data.size() != 0) begin n_fail++; $display("FAIL abort_silent: got rsp %b issues %0d required 0/0", extra, obs_data.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 24'h000000;
        rsp_ready = 1'b0;
        auto_rdy  = 1'b0;
        auto_out  = 24'h000000;
        man_rdy   = 1'b0;
        man_out   = 24'h000000;
        @(posedge clk); #1;
        test_reset();
        test_run();
        test_get_same();
        test_timeout();
        test_late_rdy();
        test_back_to_back();
        test_push_pop();
        test_wrap();
        test_rst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
